// File: rtl/sseg_scan_driver.sv
// Eight-digit common-anode seven-segment scanner with frame-synchronous update and dead time.
// Outputs registered (1-cycle latency); load_ready_out low while an update waits for the frame boundary.
module sseg_scan_driver #(
  parameter int SCAN_DIV    = 25000,
  parameter int DEAD_CYCLES = 64
) (
  input  logic        clk_in,
  input  logic        rst_low_in,
  input  logic [31:0] value_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  blank_in,
  input  logic        load_valid_in,
  output logic        load_ready_out,
  output logic        frame_done_out,
  output logic [7:0]  an_out,
  output logic [6:0]  sseg_out,
  output logic        dp_out
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEAD_C  = CW'(DEAD_CYCLES);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    dig_q, dig_d;
  logic [31:0]   act_val_q, pend_val_q;
  logic [7:0]    act_dp_q, pend_dp_q;
  logic [7:0]    act_blank_q, pend_blank_q;
  logic          pend_vld_q;
  logic          frame_done_q;
  logic [7:0]    an_q, an_d;
  logic [6:0]    sseg_q, sseg_d;
  logic          dp_q, dp_d;

  logic          last_slot, boundary, xfer, dark;
  logic [3:0]    nib;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h40;  4'h1: g = 7'h79;  4'h2: g = 7'h24;  4'h3: g = 7'h30;
      4'h4: g = 7'h19;  4'h5: g = 7'h12;  4'h6: g = 7'h02;  4'h7: g = 7'h78;
      4'h8: g = 7'h00;  4'h9: g = 7'h10;  4'hA: g = 7'h08;  4'hB: g = 7'h03;
      4'hC: g = 7'h46;  4'hD: g = 7'h21;  4'hE: g = 7'h06;  default: g = 7'h0E;
    endcase
    return g;
  endfunction

  always_comb begin
    last_slot = (cnt_q == CNT_MAX);
    boundary  = last_slot && (dig_q == 3'd7);
    xfer      = load_valid_in && !pend_vld_q;
    cnt_d     = last_slot ? '0 : cnt_q + CW'(1);
    dig_d     = last_slot ? dig_q + 3'd1 : dig_q;
    nib       = act_val_q[{dig_q, 2'b00} +: 4];
    // Dead time keeps the previous digit's segments from ghosting onto the next anode.
    dark      = (cnt_q < DEAD_C) || act_blank_q[dig_q];
    an_d      = dark ? 8'hFF : ~(8'h01 << dig_q);
    sseg_d    = dark ? 7'h7F : glyph(nib);
    dp_d      = dark ? 1'b1  : ~act_dp_q[dig_q];
  end

  always_ff @(posedge clk_in or negedge rst_low_in) begin
    if (!rst_low_in) begin
      cnt_q        <= '0;
      dig_q        <= '0;
      act_val_q    <= '0;
      act_dp_q     <= '0;
      act_blank_q  <= 8'hFF;
      pend_val_q   <= '0;
      pend_dp_q    <= '0;
      pend_blank_q <= 8'hFF;
      pend_vld_q   <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= 8'hFF;
      sseg_q       <= 7'h7F;
      dp_q         <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      dig_q        <= dig_d;
      frame_done_q <= boundary;
      an_q         <= an_d;
      sseg_q       <= sseg_d;
      dp_q         <= dp_d;
      if (boundary) begin
        // A load landing on the boundary bypasses the pending set entirely.
        if (xfer) begin
          act_val_q   <= value_in;
          act_dp_q    <= dp_in;
          act_blank_q <= blank_in;
        end else if (pend_vld_q) begin
          act_val_q   <= pend_val_q;
          act_dp_q    <= pend_dp_q;
          act_blank_q <= pend_blank_q;
          pend_vld_q  <= 1'b0;
        end
      end else if (xfer) begin
        pend_val_q   <= value_in;
        pend_dp_q    <= dp_in;
        pend_blank_q <= blank_in;
        pend_vld_q   <= 1'b1;
      end
    end
  end

  assign load_ready_out = !pend_vld_q;
  assign frame_done_out = frame_done_q;
  assign an_out         = an_q;
  assign sseg_out       = sseg_q;
  assign dp_out         = dp_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver: time-indexed display model plus directed frame checks.
module tb_sseg_scan_driver;
  localparam int SD   = 4;
  localparam int DEAD = 1;
  localparam int FRAME = 8 * SD;

  logic        clk_in = 1'b0;
  logic        rst_low_in = 1'b1;
  logic [31:0] value_in = '0;
  logic [7:0]  dp_in = '0;
  logic [7:0]  blank_in = '0;
  logic        load_valid_in = 1'b0;
  logic        load_ready_out, frame_done_out, dp_out;
  logic [7:0]  an_out;
  logic [6:0]  sseg_out;

  sseg_scan_driver #(.SCAN_DIV(SD), .DEAD_CYCLES(DEAD)) dut (
    .clk_in(clk_in), .rst_low_in(rst_low_in), .value_in(value_in), .dp_in(dp_in),
    .blank_in(blank_in), .load_valid_in(load_valid_in), .load_ready_out(load_ready_out),
    .frame_done_out(frame_done_out), .an_out(an_out), .sseg_out(sseg_out), .dp_out(dp_out)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] glyph_tab [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference state: cycles since reset release, plus displayed and waiting data.
  int          t;
  logic [31:0] a_val, p_val;
  logic [7:0]  a_dp, a_bl, p_dp, p_bl;
  bit          p_vld;
  logic [7:0]  e_an;
  logic [6:0]  e_sseg;
  logic        e_dp, e_fd, e_rdy;

  task automatic model_reset();
    t = 0; a_val = '0; a_dp = '0; a_bl = 8'hFF;
    p_val = '0; p_dp = '0; p_bl = 8'hFF; p_vld = 0;
  endtask

  // Advance one clock; leaves e_* holding what the DUT should show 1ns after the edge.
  task automatic tick();
    int cnt, dig;
    bit bnd, xf;
    logic [3:0] nib;
    cnt = t % SD;
    dig = (t / SD) % 8;
    bnd = (cnt == SD - 1) && (dig == 7);
    xf  = load_valid_in && !p_vld;
    nib = 4'(a_val >> (4 * dig));
    if (cnt < DEAD || a_bl[dig]) begin
      e_an = 8'hFF; e_sseg = 7'h7F; e_dp = 1'b1;
    end else begin
      e_an = 8'hFF ^ 8'(1 << dig); e_sseg = glyph_tab[nib]; e_dp = !a_dp[dig];
    end
    e_fd = bnd;
    @(posedge clk_in);
    if (bnd) begin
      if (xf) begin
        a_val = value_in; a_dp = dp_in; a_bl = blank_in;
      end else if (p_vld) begin
        a_val = p_val; a_dp = p_dp; a_bl = p_bl; p_vld = 0;
      end
    end else if (xf) begin
      p_val = value_in; p_dp = dp_in; p_bl = blank_in; p_vld = 1;
    end
    t++;
    e_rdy = !p_vld;
    #1;
  endtask

  task automatic test_reset();
    int fd_cnt;
    #1 rst_low_in = 1'b0;
    #2;
    n_cmp++;
    if ({an_out, sseg_out, dp_out, frame_done_out, load_ready_out} !== {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL reset_values got %h want %h", {an_out, sseg_out, dp_out, frame_done_out, load_ready_out}, {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b1});
    end
    @(posedge clk_in); #1 rst_low_in = 1'b1;
    model_reset();
    fd_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      tick();
      if (frame_done_out) fd_cnt++;
      n_cmp++;
      if ({an_out, sseg_out, dp_out, frame_done_out, load_ready_out} !== {e_an, e_sseg, e_dp, e_fd, e_rdy}) begin
        n_bad++; $display("FAIL idle_dark t=%0d got %h want %h", t, {an_out, sseg_out, dp_out, frame_done_out, load_ready_out}, {e_an, e_sseg, e_dp, e_fd, e_rdy});
      end
    end
    n_cmp++;
    if (fd_cnt !== 2) begin
      n_bad++; $display("FAIL idle_frame_pulses got %0d want 2", fd_cnt);
    end
  endtask

  task automatic test_load_frame();
    bit seen = 0;
    value_in = 32'h0123ABCF; dp_in = 8'h01; blank_in = 8'h00; load_valid_in = 1'b1;
    tick();
    load_valid_in = 1'b0; value_in = $urandom; dp_in = 8'($urandom); blank_in = 8'($urandom);
    for (int i = 0; i < FRAME + 2 && !seen; i++) begin
      tick();
      seen = e_fd;
      n_cmp++;
      if ({an_out, sseg_out, dp_out, frame_done_out, load_ready_out} !== {e_an, e_sseg, e_dp, e_fd, e_rdy}) begin
        n_bad++; $display("FAIL load_wait t=%0d got %h want %h", t, {an_out, sseg_out, dp_out, frame_done_out, load_ready_out}, {e_an, e_sseg, e_dp, e_fd, e_rdy});
      end
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL load_boundary_timeout got none want frame_done"); end
    for (int k = 1; k <= FRAME; k++) begin
      tick();
      n_cmp++;
      if ({an_out, sseg_out, dp_out, frame_done_out, load_ready_out} !== {e_an, e_sseg, e_dp, e_fd, e_rdy}) begin
        n_bad++; $display("FAIL load_frame k=%0d got %h want %h", k, {an_out, sseg_out, dp_out, frame_done_out, load_ready_out}, {e_an, e_sseg, e_dp, e_fd, e_rdy});
      end
      if (k == 1 || (k >= 2 && k <= 4) || k >= 30) begin
        n_cmp++;
        if (k == 1 && {an_out, sseg_out, dp_out} !== {8'hFF, 7'h7F, 1'b1}) begin
          n_bad++; $display("FAIL slot0_dead k=%0d got %h want %h", k, {an_out, sseg_out, dp_out}, {8'hFF, 7'h7F, 1'b1});
        end else if (k >= 2 && k <= 4 && {an_out, sseg_out, dp_out} !== {8'hFE, 7'h0E, 1'b0}) begin
          n_bad++; $display("FAIL slot0_lit k=%0d got %h want %h", k, {an_out, sseg_out, dp_out}, {8'hFE, 7'h0E, 1'b0});
        end else if (k >= 30 && {an_out, sseg_out} !== {8'h7F, 7'h40}) begin
          n_bad++; $display("FAIL slot7_lit k=%0d got %h want %h", k, {an_out, sseg_out}, {8'h7F, 7'h40});
        end
      end
    end
  endtask

  task automatic test_hold_off();
    bit seen = 0;
    value_in = 32'h00000005; dp_in = 8'h00; blank_in = 8'h00; load_valid_in = 1'b1;
    tick();
    value_in = 32'h0000000C;
    for (int i = 0; i < FRAME + 2 && !seen; i++) begin
      tick();
      seen = e_fd;
      n_cmp++;
      if ({an_out, sseg_out, dp_out, frame_done_out, load_ready_out} !== {e_an, e_sseg, e_dp, e_fd, e_rdy}) begin
        n_bad++; $display("FAIL hold_wait t=%0d got %h want %h", t, {an_out, sseg_out, dp_out, frame_done_out, load_ready_out}, {e_an, e_sseg, e_dp, e_fd, e_rdy});
      end
    end
    n_cmp++;
    if (!seen || load_ready_out !== 1'b1) begin
      n_bad++; $display("FAIL hold_ready_at_boundary got seen=%0d rdy=%b want seen=1 rdy=1", seen, load_ready_out);
    end
    seen = 0;
    for (int k = 1; k <= 2 * FRAME && !(seen && k > FRAME + 4); k++) begin
      tick();
      if (k == 1) load_valid_in = 1'b0;
      n_cmp++;
      if ({an_out, sseg_out, dp_out, frame_done_out, load_ready_out} !== {e_an, e_sseg, e_dp, e_fd, e_rdy}) begin
        n_bad++; $display("FAIL hold_frame k=%0d got %h want %h", k, {an_out, sseg_out, dp_out, frame_done_out, load_ready_out}, {e_an, e_sseg, e_dp, e_fd, e_rdy});
      end
      if (k == 1) begin
        n_cmp++;
        if (load_ready_out !== 1'b0) begin n_bad++; $display("FAIL hold_second_accept got rdy=%b want 0", load_ready_out); end
      end
      if (k >= 2 && k <= 4) begin
        n_cmp++;
        if (sseg_out !== 7'h12) begin n_bad++; $display("FAIL hold_first_shown k=%0d got %h want 12", k, sseg_out); end
      end
      if (k >= FRAME + 2 && k <= FRAME + 4) begin
        seen = 1;
        n_cmp++;
        if (sseg_out !== 7'h46) begin n_bad++; $display("FAIL hold_second_shown k=%0d got %h want 46", k, sseg_out); end
      end
    end
  endtask

  task automatic test_boundary_load();
    int lit = 0;
    for (int i = 0; i < FRAME + 2 && (t % FRAME) != FRAME - 1; i++) begin
      tick();
      n_cmp++;
      if ({an_out, sseg_out, dp_out, frame_done_out, load_ready_out} !== {e_an, e_sseg, e_dp, e_fd, e_rdy}) begin
        n_bad++; $display("FAIL bnd_wait t=%0d got %h want %h", t, {an_out, sseg_out, dp_out, frame_done_out, load_ready_out}, {e_an, e_sseg, e_dp, e_fd, e_rdy});
      end
    end
    value_in = 32'h88888888; dp_in = 8'h00; blank_in = 8'h00; load_valid_in = 1'b1;
    tick();
    load_valid_in = 1'b0;
    n_cmp++;
    if ({frame_done_out, load_ready_out} !== 2'b11) begin
      n_bad++; $display("FAIL bnd_ready_kept got fd/rdy=%b want 11", {frame_done_out, load_ready_out});
    end
    for (int k = 1; k <= FRAME; k++) begin
      tick();
      n_cmp++;
      if ({an_out, sseg_out, dp_out, frame_done_out, load_ready_out} !== {e_an, e_sseg, e_dp, e_fd, e_rdy}) begin
        n_bad++; $display("FAIL bnd_frame k=%0d got %h want %h", k, {an_out, sseg_out, dp_out, frame_done_out, load_ready_out}, {e_an, e_sseg, e_dp, e_fd, e_rdy});
      end
      if (an_out != 8'hFF) begin
        lit++;
        n_cmp++;
        if (sseg_out !== 7'h00) begin n_bad++; $display("FAIL bnd_eights k=%0d got %h want 00", k, sseg_out); end
      end
    end
    n_cmp++;
    if (lit !== 8 * (SD - DEAD)) begin n_bad++; $display("FAIL bnd_lit_cycles got %0d want %0d", lit, 8 * (SD - DEAD)); end
  endtask

  task automatic test_blank();
    int lit = 0;
    bit seen = 0;
    value_in = 32'h11111111; dp_in = 8'h00; blank_in = 8'hAA; load_valid_in = 1'b1;
    tick();
    load_valid_in = 1'b0;
    for (int i = 0; i < FRAME + 2 && !seen; i++) begin
      tick();
      seen = e_fd;
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL blank_boundary_timeout got none want frame_done"); end
    for (int k = 1; k <= FRAME; k++) begin
      tick();
      n_cmp++;
      if ({an_out, sseg_out, dp_out, frame_done_out, load_ready_out} !== {e_an, e_sseg, e_dp, e_fd, e_rdy}) begin
        n_bad++; $display("FAIL blank_frame k=%0d got %h want %h", k, {an_out, sseg_out, dp_out, frame_done_out, load_ready_out}, {e_an, e_sseg, e_dp, e_fd, e_rdy});
      end
      if (an_out != 8'hFF) begin
        lit++;
        n_cmp++;
        if (sseg_out !== 7'h79 || (an_out[1] & an_out[3] & an_out[5] & an_out[7]) !== 1'b1) begin
          n_bad++; $display("FAIL blank_even_only k=%0d got an=%h sseg=%h want even anode sseg=79", k, an_out, sseg_out);
        end
      end
    end
    n_cmp++;
    if (lit !== 4 * (SD - DEAD)) begin n_bad++; $display("FAIL blank_lit_cycles got %0d want %0d", lit, 4 * (SD - DEAD)); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 800; i++) begin
      load_valid_in = ($urandom_range(0, 3) == 0);
      value_in = $urandom; dp_in = 8'($urandom); blank_in = 8'($urandom) & 8'($urandom);
      tick();
      n_cmp++;
      if ({an_out, sseg_out, dp_out, frame_done_out, load_ready_out} !== {e_an, e_sseg, e_dp, e_fd, e_rdy}) begin
        n_bad++; $display("FAIL random t=%0d got %h want %h", t, {an_out, sseg_out, dp_out, frame_done_out, load_ready_out}, {e_an, e_sseg, e_dp, e_fd, e_rdy});
      end
    end
    load_valid_in = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    for (int i = 0; i < FRAME + 2 && !(seen && p_vld); i++) begin
      load_valid_in = !p_vld;
      value_in = 32'h76543210; dp_in = 8'hFF; blank_in = 8'h00;
      tick();
      seen = seen || e_fd;
    end
    load_valid_in = 1'b1; value_in = 32'hFFFFFFFF;
    for (int i = 0; i < FRAME + 2 && !(t % FRAME == 2 && p_vld); i++) tick();
    load_valid_in = 1'b0;
    n_cmp++;
    if (an_out === 8'hFF || load_ready_out !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_precond got an=%h rdy=%b want lit anode rdy=0", an_out, load_ready_out);
    end
    #2 rst_low_in = 1'b0;
    #1;
    n_cmp++;
    if ({an_out, sseg_out, dp_out, frame_done_out, load_ready_out} !== {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b1}) begin
      n_bad++; $display("FAIL rstmid_async got %h want %h", {an_out, sseg_out, dp_out, frame_done_out, load_ready_out}, {8'hFF, 7'h7F, 1'b1, 1'b0, 1'b1});
    end
    @(posedge clk_in); @(posedge clk_in); #1 rst_low_in = 1'b1;
    model_reset();
    for (int i = 0; i < 2 * FRAME; i++) begin
      tick();
      n_cmp++;
      if ({an_out, sseg_out, dp_out, frame_done_out, load_ready_out} !== {e_an, e_sseg, e_dp, e_fd, e_rdy}) begin
        n_bad++; $display("FAIL rstmid_after t=%0d got %h want %h", t, {an_out, sseg_out, dp_out, frame_done_out, load_ready_out}, {e_an, e_sseg, e_dp, e_fd, e_rdy});
      end
      if (an_out !== 8'hFF || load_ready_out !== 1'b1) begin
        n_cmp++; n_bad++;
        $display("FAIL rstmid_dark t=%0d got an=%h rdy=%b want an=ff rdy=1", t, an_out, load_ready_out);
      end
    end
  endtask

  initial begin
    model_reset();
    e_an = 8'hFF; e_sseg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0; e_rdy = 1'b1;
    test_reset();
    test_load_frame();
    test_hold_off();
    test_boundary_load();
    test_blank();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "bench did not complete");
  end

endmodule
